// File: rtl/voxel_ram_arbiter.sv
// Single-port voxel RAM arbiter: loader writes win, traversal-unit reads are served round-robin,
// read data is routed back by a one-hot tag pipeline. Optional macro: VOXEL_ARB_STARVE_GUARD_EN.
module voxel_ram_arbiter #(
    parameter int NUM_READERS  = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 5,
    parameter int RAM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [NUM_READERS-1:0]            rd_req,
    input  logic [NUM_READERS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READERS-1:0]            rd_grant,
    output logic [NUM_READERS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]             rd_data,
    input  logic                              wr_req,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              wr_grant,
    output logic [ADDR_WIDTH-1:0]             ram_addr,
    output logic [DATA_WIDTH-1:0]             ram_wdata,
    output logic                              ram_we,
    output logic                              ram_re,
    input  logic [DATA_WIDTH-1:0]             ram_rdata,
    output logic                              busy_out
);
    localparam int PW = $clog2(NUM_READERS);

    // Handshake: a request completes in the cycle where req && grant; the requester may drop or
    // re-raise req afterwards. Read data returns later as a one-hot rd_valid pulse, in grant order.

    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          rd_idx;
    logic                   rd_any;
    logic [ADDR_WIDTH-1:0]  rd_sel_addr;
    logic                   read_prio;
    logic                   wr_win;
    logic                   rd_win;
    logic [NUM_READERS-1:0] issue_tag;
    logic [NUM_READERS-1:0] tag_pipe [RAM_LATENCY];
    logic                   pipe_any;

    // Round-robin search starting just after the last served reader.
    always_comb begin
        rd_idx      = '0;
        rd_any      = 1'b0;
        rd_sel_addr = '0;
        for (int k = 1; k <= NUM_READERS; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_READERS;
            if (!rd_any && rd_req[j]) begin
                rd_any      = 1'b1;
                rd_idx      = PW'(j);
                rd_sel_addr = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

`ifdef VOXEL_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign read_prio = (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            starve_cnt <= '0;
        end else if (rd_win || !(|rd_req)) begin
            starve_cnt <= '0;
        end else if (wr_win && starve_cnt != CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign read_prio = 1'b0;
`endif

    // Grants are forced low while reset is held so nothing completes during reset.
    always_comb begin
        wr_win   = rst_in && wr_req && !(read_prio && rd_any);
        rd_win   = rst_in && rd_any && !wr_win;
        wr_grant = wr_win;
        rd_grant = rd_win ? (NUM_READERS'(1) << rd_idx) : '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr    <= PW'(NUM_READERS - 1);
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            issue_tag <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            ram_we    <= wr_win;
            ram_re    <= rd_win;
            issue_tag <= rd_grant;
            if (wr_win) begin
                ram_addr  <= wr_addr;
                ram_wdata <= wr_data;
            end else if (rd_win) begin
                ram_addr <= rd_sel_addr;
                rr_ptr   <= rd_idx;
            end
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < RAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < RAM_LATENCY; i++) pipe_any = pipe_any | (|tag_pipe[i]);
    end

    assign rd_valid = tag_pipe[RAM_LATENCY-1];
    assign rd_data  = (|tag_pipe[RAM_LATENCY-1]) ? ram_rdata : '0;
    assign busy_out = ram_we | ram_re | pipe_any;

endmodule

// File: tb/tb_voxel_ram_arbiter.sv
// Directed bench for voxel_ram_arbiter with a behavioural 2-cycle-latency RAM.
module tb_voxel_ram_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 5;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [N-1:0]    rd_req;
    logic [N*AW-1:0] rd_addr;
    logic [N-1:0]    rd_grant;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_grant;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic            ram_we;
    logic            ram_re;
    logic [DW-1:0]   ram_rdata;
    logic            busy_out;

    int checks   = 0;
    int failures = 0;

    voxel_ram_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: contents preloaded while reset is low; read data appears two edges after ram_re.
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] rd_d1, rd_d2;
    always @(posedge clk_in) begin
        if (!rst_in) begin
            mem[16'h0123] <= 5'd7;
            mem[16'h0040] <= 5'd3;
            mem[16'h0200] <= 5'd10;
            mem[16'h0201] <= 5'd11;
            mem[16'h0202] <= 5'd12;
            mem[16'h0203] <= 5'd13;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_re) rd_d1 <= mem[ram_addr];
        rd_d2 <= rd_d1;
    end
    assign ram_rdata = rd_d2;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [N-1:0] exp_rg;
        logic         exp_wg;

        // Reset with requests asserted: grants must stay low.
        rst_in  = 1'b0;
        rd_req  = 4'hF;
        rd_addr = '0;
        wr_req  = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        step(); step(); step();
        mid();
        chk("rst_rd_grant", 32'(rd_grant), 0);
        chk("rst_wr_grant", 32'(wr_grant), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_re", 32'(ram_re), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_busy", 32'(busy_out), 0);
        step();
        rd_req = '0;
        wr_req = 1'b0;
        rst_in = 1'b1;

        // Single read: reader 2 at 0x0123 holding 7.
        step();
        rd_req = 4'b0100;
        rd_addr[2*AW +: AW] = 16'h0123;
        mid();
        chk("single_grant", 32'(rd_grant), 32'h4);
        chk("single_wgrant", 32'(wr_grant), 0);
        step();
        rd_req = '0;
        mid();
        chk("single_re", 32'(ram_re), 1);
        chk("single_we", 32'(ram_we), 0);
        chk("single_addr", 32'(ram_addr), 32'h0123);
        chk("single_busy", 32'(busy_out), 1);
        chk("single_idle_grant", 32'(rd_grant), 0);
        step();
        mid();
        chk("single_valid_t2", 32'(rd_valid), 0);
        step();
        mid();
        chk("single_valid_t3", 32'(rd_valid), 32'h4);
        chk("single_data_t3", 32'(rd_data), 7);
        chk("single_busy_t3", 32'(busy_out), 1);
        step();
        mid();
        chk("idle_valid", 32'(rd_valid), 0);
        chk("idle_re", 32'(ram_re), 0);
        chk("idle_we", 32'(ram_we), 0);
        chk("idle_busy", 32'(busy_out), 0);

        // Reset one cycle after a read grant: the read must never return.
        step();
        rd_req = 4'b0010;
        rd_addr[1*AW +: AW] = 16'h0201;
        mid();
        chk("rstmid_grant", 32'(rd_grant), 32'h2);
        step();
        rd_req = '0;
        rst_in = 1'b0;
        #1;
        chk("rstmid_re", 32'(ram_re), 0);
        chk("rstmid_addr", 32'(ram_addr), 0);
        chk("rstmid_busy", 32'(busy_out), 0);
        step();
        step();
        rst_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("rstmid_no_valid", 32'(rd_valid), 0);
            chk("rstmid_no_busy", 32'(busy_out), 0);
            step();
        end

        // All four readers back-to-back from a fresh pointer.
        for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = 16'h0200 + 16'(i);
        for (int k = 0; k < 9; k++) begin
            rd_req = (k < 6) ? 4'hF : 4'h0;
            mid();
            chk("rr_grant", 32'(rd_grant), (k < 6) ? (32'h1 << (k % 4)) : 32'h0);
            if (k >= 3) begin
                chk("rr_valid", 32'(rd_valid), 32'h1 << ((k - 3) % 4));
                chk("rr_data", 32'(rd_data), 32'(10 + (k - 3) % 4));
            end
            step();
        end

        // Write beats a simultaneous read; a read of the same address then sees the new value.
        wr_req  = 1'b1;
        wr_addr = 16'h0040;
        wr_data = 5'd9;
        rd_req  = 4'b0010;
        rd_addr[1*AW +: AW] = 16'h0040;
        mid();
        chk("raw_wgrant", 32'(wr_grant), 1);
        chk("raw_rgrant_blocked", 32'(rd_grant), 0);
        step();
        wr_req = 1'b0;
        mid();
        chk("raw_rgrant", 32'(rd_grant), 32'h2);
        chk("raw_we", 32'(ram_we), 1);
        chk("raw_waddr", 32'(ram_addr), 32'h0040);
        chk("raw_wdata", 32'(ram_wdata), 9);
        step();
        rd_req = '0;
        mid();
        chk("raw_re", 32'(ram_re), 1);
        step();
        step();
        mid();
        chk("raw_valid", 32'(rd_valid), 32'h2);
        chk("raw_data", 32'(rd_data), 9);

        // Write stream for 20 cycles with reader 0 waiting.
        for (int k = 0; k <= 20; k++) begin
            step();
            wr_req  = (k < 20);
            wr_addr = 16'h0300 + 16'(k);
            wr_data = 5'(k);
`ifdef VOXEL_ARB_STARVE_GUARD_EN
            rd_req = (k <= 8) ? 4'b0001 : 4'b0000;
            exp_wg = (k < 20) && (k != 8);
            exp_rg = (k == 8) ? 4'b0001 : 4'b0000;
`else
            rd_req = 4'b0001;
            exp_wg = (k < 20);
            exp_rg = (k == 20) ? 4'b0001 : 4'b0000;
`endif
            rd_addr[0*AW +: AW] = 16'h0200;
            mid();
            chk("stream_wgrant", 32'(wr_grant), 32'(exp_wg));
            chk("stream_rgrant", 32'(rd_grant), 32'(exp_rg));
        end
        step();
        rd_req = '0;
        wr_req = 1'b0;
        step(); step(); step(); step();
        mid();
        chk("drain_busy", 32'(busy_out), 0);
        chk("drain_we", 32'(ram_we), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
